// File: rtl/store_align_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_align_buffer_pkg
//   Shared definitions for the MEM-stage store path.
//   - Store-op encodings. They use the same values as the load extender select
//     so the control unit can drive both paths from one decode table.
//   - Byte-enable constants for word, halfword and byte lanes.
//   - Layout of one buffered store entry.
// -----------------------------------------------------------------------------
package store_align_buffer_pkg;

    localparam logic [1:0] ST_W = 2'd0;
    localparam logic [1:0] ST_H = 2'd1;
    localparam logic [1:0] ST_B = 2'd2;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // The word address is kept without its two zero LSBs.
    typedef struct packed {
        logic [29:0] word_addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_entry_t;

endpackage

// File: rtl/store_lane_fmt.sv
// -----------------------------------------------------------------------------
// store_lane_fmt
//   Combinational lane formatter. It turns a register value into
//   lane-replicated write data and byte enables. It also flags misaligned or
//   illegal stores.
//   Ports:
//     op      in  2   store type (ST_W / ST_H / ST_B, 3 = illegal)
//     addr_lo in  2   byte offset within the word (st_addr[1:0])
//     data    in  32  source register value
//     be      out 4   byte enables, bit i = byte lane i
//     wdata   out 32  lane-replicated write data
//     err     out 1   misaligned access or illegal op
// -----------------------------------------------------------------------------
module store_lane_fmt
    import store_align_buffer_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        err
);

    always_comb begin
        be    = '0;
        wdata = '0;
        err   = 1'b0;
        case (op)
            ST_W: begin
                be    = BE_WORD;
                wdata = data;
                err   = (addr_lo != 2'b00);
            end
            ST_H: begin
                be    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata = {2{data[15:0]}};
                err   = addr_lo[0];
            end
            ST_B: begin
                be    = BE_BYTE0 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_align_buffer.sv
// -----------------------------------------------------------------------------
// store_align_buffer
//   Write-side store buffer for the MEM stage. It formats stores into byte
//   lanes and queues up to DEPTH of them in FIFO order. It drains them to data
//   memory over a valid/ack handshake. It also flags loads that hit a
//   buffered store word.
//   Ports:
//     clk        in   1        system clock, rising edge
//     rst_n      in   1        asynchronous active-low reset
//     st_valid   in   1        store presented this cycle
//     st_op      in   2        0 = sw, 1 = sh, 2 = sb, 3 = illegal
//     st_addr    in   32       store byte address
//     st_data    in   32       store source register value
//     st_ready   out  1        buffer not full
//     ld_valid   in   1        load presented this cycle
//     ld_addr    in   32       load byte address
//     ld_hazard  out  1        load word matches a buffered store
//     mem_we     out  1        head entry valid (write request)
//     mem_addr   out  32       head word address
//     mem_be     out  4        head byte enables
//     mem_wdata  out  32       head write data
//     mem_ack    in   1        memory accepted the head write
//     align_err  out  1        one-cycle pulse: bad store dropped
//     occupancy  out  PTR_W+1  number of valid entries
// -----------------------------------------------------------------------------
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid,
    input  logic [1:0]       st_op,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_hazard,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    output logic             align_err,
    output logic [PTR_W:0]   occupancy
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    store_entry_t     entry_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [3:0]       fmt_be;
    logic [31:0]      fmt_wdata;
    logic             fmt_err;
    logic             push;
    logic             pop;

    // Only the word part of the load address matters for the hazard compare.
    logic             unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    store_lane_fmt u_fmt (
        .op      (st_op),
        .addr_lo (st_addr[1:0]),
        .data    (st_data),
        .be      (fmt_be),
        .wdata   (fmt_wdata),
        .err     (fmt_err)
    );

    // st_ready depends only on the registered count. A dequeue in the same
    // cycle does not open a slot until the next cycle.
    assign st_ready  = (count != FULL_CNT);
    assign mem_we    = (count != '0);
    assign occupancy = count;
    assign push      = st_valid && st_ready && !fmt_err;
    assign pop       = mem_we && mem_ack;

    // Control state: pointers, count, per-entry valid bits, error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            vld_q     <= '0;
            align_err <= 1'b0;
        end else begin
            align_err <= st_valid && st_ready && fmt_err;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            // A push never targets the slot being popped. A push needs a free
            // slot, and a pop needs an occupied one.
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
            end
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
            end
        end
    end

    // Entry payload has no reset. It is only observed through vld_q/count.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wr_ptr] <= '{word_addr: st_addr[31:2], be: fmt_be, wdata: fmt_wdata};
        end
    end

    // Head outputs are forced to zero when the buffer is empty. This hides
    // stale payload and keeps the bus quiet after reset.
    always_comb begin
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (mem_we) begin
            mem_addr  = {entry_q[rd_ptr].word_addr, 2'b00};
            mem_be    = entry_q[rd_ptr].be;
            mem_wdata = entry_q[rd_ptr].wdata;
        end
    end

    // The store presented this same cycle is deliberately excluded; forwarding
    // handles that case.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_valid && vld_q[i] && (entry_q[i].word_addr == ld_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_align_buffer.sv
module tb_store_align_buffer;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic             clk;
    logic             rst_n;
    logic             st_valid;
    logic [1:0]       st_op;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             st_ready;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_hazard;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic             align_err;
    logic [PTR_W:0]   occupancy;

    store_align_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .align_err (align_err),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    bit   exp_err;
    int   checks;
    int   errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference formatter. The access size is 4/2/1 bytes. The access covers
    // lanes [offset, offset+size). Lane k carries source byte (k % size). The
    // access is an error if the offset is not a multiple of the size, or if
    // op is 3.
    function automatic void ref_fmt(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] d, output logic [3:0] be,
                                    output logic [31:0] wd, output bit err);
        int size;
        int off;
        be  = '0;
        wd  = '0;
        err = 1'b0;
        if (op == 2'd3) begin
            err = 1'b1;
            return;
        end
        size = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
        off  = int'(a % 4);
        err  = (off % size) != 0;
        for (int k = 0; k < 4; k++) begin
            if (k >= off - (off % size) && k < off - (off % size) + size)
                be[k] = 1'b1;
            wd[8*k +: 8] = d[8*(k % size) +: 8];
        end
    endfunction

    // One clock cycle. Drive the inputs, check the outputs against the model
    // state, advance the model, then cross the rising edge.
    task automatic cyc(input bit sv, input logic [1:0] op, input logic [31:0] sa,
                       input logic [31:0] sd, input bit lv, input logic [31:0] la,
                       input bit ack);
        logic [3:0]  be;
        logic [31:0] wd;
        bit          err;
        bit          rdy;
        bit          haz;
        bit          acc;
        st_valid = sv; st_op = op; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la; mem_ack = ack;
        #1;
        rdy = q.size() < DEPTH;
        haz = 1'b0;
        foreach (q[i]) if (lv && (q[i].addr >> 2) == (la >> 2)) haz = 1'b1;
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("mem_we", 32'(mem_we), 32'(q.size() != 0));
        chk("mem_addr", mem_addr, q.size() != 0 ? q[0].addr : 32'h0);
        chk("mem_be", 32'(mem_be), q.size() != 0 ? 32'(q[0].be) : 32'h0);
        chk("mem_wdata", mem_wdata, q.size() != 0 ? q[0].data : 32'h0);
        chk("st_ready", 32'(st_ready), 32'(rdy));
        chk("ld_hazard", 32'(ld_hazard), 32'(haz));
        chk("align_err", 32'(align_err), 32'(exp_err));
        ref_fmt(op, sa, sd, be, wd, err);
        acc = sv && rdy;
        if (q.size() != 0 && ack) void'(q.pop_front());
        if (acc && !err) q.push_back('{addr: {sa[31:2], 2'b00}, be: be, data: wd});
        exp_err = acc && err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit ack);
        cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0, ack);
    endtask

    initial begin
        checks = 0; errors = 0; exp_err = 1'b0;
        rst_n = 1'b0; st_valid = 1'b0; st_op = 2'd0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_align_err", 32'(align_err), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // sb to 0x103 lands on lane 3 of word 0x100
        cyc(1'b1, 2'd2, 32'h0000_0103, 32'h0000_00AB, 1'b0, 32'h0, 1'b0);
        chk("tp1_we", 32'(mem_we), 32'h1);
        chk("tp1_addr", mem_addr, 32'h0000_0100);
        chk("tp1_be", 32'(mem_be), 32'h8);
        chk("tp1_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("tp1_occ", 32'(occupancy), 32'h1);
        idle(1'b1);
        idle(1'b0);

        // Fill the buffer, drop a store while full, then drain one entry
        cyc(1'b1, 2'd1, 32'h0000_0202, 32'h1234_BEEF, 1'b0, 32'h0, 1'b0);
        chk("tp2_be_hi", 32'(mem_be), 32'hC);
        chk("tp2_wdata", mem_wdata, 32'hBEEF_BEEF);
        cyc(1'b1, 2'd0, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
        chk("tp2_full", 32'(st_ready), 32'h0);
        cyc(1'b1, 2'd0, 32'h0000_0500, 32'h1111_2222, 1'b0, 32'h0, 1'b0);
        chk("tp2_no_err", 32'(align_err), 32'h0);
        cyc(1'b1, 2'd0, 32'h0000_0500, 32'h1111_2222, 1'b0, 32'h0, 1'b1);
        chk("tp2_head_addr", mem_addr, 32'h0000_0300);
        chk("tp2_head_be", 32'(mem_be), 32'hF);
        chk("tp2_ready_back", 32'(st_ready), 32'h1);
        idle(1'b1);
        idle(1'b0);

        // Misaligned and illegal stores are dropped with a one-cycle pulse
        cyc(1'b1, 2'd0, 32'h0000_0006, 32'h5555_5555, 1'b0, 32'h0, 1'b0);
        chk("tp3_sw_err", 32'(align_err), 32'h1);
        chk("tp3_sw_occ", 32'(occupancy), 32'h0);
        idle(1'b0);
        chk("tp3_sw_pulse", 32'(align_err), 32'h0);
        cyc(1'b1, 2'd1, 32'h0000_0001, 32'h5555_5555, 1'b0, 32'h0, 1'b0);
        chk("tp3_sh_err", 32'(align_err), 32'h1);
        chk("tp3_sh_we", 32'(mem_we), 32'h0);
        cyc(1'b1, 2'd3, 32'h0000_0000, 32'h5555_5555, 1'b0, 32'h0, 1'b0);
        chk("tp3_ill_err", 32'(align_err), 32'h1);
        idle(1'b0);
        idle(1'b0);

        // Load-after-store hazard against a buffered word
        cyc(1'b1, 2'd0, 32'h0000_0400, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0000_0402, 1'b0);
        cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0000_0404, 1'b0);
        cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0000_0402, 1'b1);
        ld_valid = 1'b1; ld_addr = 32'h0000_0402; #1;
        chk("tp4_haz_clear", 32'(ld_hazard), 32'h0);
        idle(1'b0);

        // Simultaneous push/pop keeps occupancy at 1 and wraps the pointers
        cyc(1'b1, 2'd0, 32'h0000_0600, 32'hA000_0000, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 2 * DEPTH + 1; i++) begin
            cyc(1'b1, 2'd0, 32'h0000_0600 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 1'b1);
            chk("tp5_occ", 32'(occupancy), 32'h1);
            chk("tp5_head", mem_addr, 32'h0000_0600 + 32'(4 * i));
        end
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset with two entries pending
        cyc(1'b1, 2'd0, 32'h0000_0700, 32'h7777_0000, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 2'd0, 32'h0000_0704, 32'h7777_0004, 1'b0, 32'h0, 1'b0);
        st_valid = 1'b0; mem_ack = 1'b0; ld_valid = 1'b1; ld_addr = 32'h0000_0700;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("tp6_we", 32'(mem_we), 32'h0);
        chk("tp6_occ", 32'(occupancy), 32'h0);
        chk("tp6_err", 32'(align_err), 32'h0);
        chk("tp6_haz", 32'(ld_hazard), 32'h0);
        q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 2'd2, 32'h0000_0801, 32'h0000_0042, 1'b0, 32'h0, 1'b0);
        chk("tp6_sb_be", 32'(mem_be), 32'h2);
        idle(1'b1);
        idle(1'b0);

        // Randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [1:0]  op;
            a  = 32'h0000_1000 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            op = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            cyc($urandom_range(0, 3) != 0, op, a, $urandom,
                $urandom_range(0, 1) == 1, 32'h0000_1000 + 32'($urandom_range(0, 15)),
                $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
